// File: rtl/cpu_controller.sv
// Moore controller that sequences instruction fetch, PC update, decode, execute and write-back
// for the simple CPU datapath and its instruction/data memory interface.
//
// state  | meaning
// -------+----------------------------------------------------------
// RST    | clear and load PC
// IF1    | present PC to memory, read
// IF2    | read continues, capture instruction into IR
// UPD    | load incremented PC
// DEC    | decode opcode/op, pick instruction path
// WIMM   | write sign-extended immediate into Rn
// GETA   | load Rn into A
// GETB   | load Rm into B
// EXEC   | ALU/shifter result into C
// CMPX   | compare, update status only
// WREG   | write C into Rd
// ADDR   | compute Rn + sximm5 into C
// LADDR  | latch C into data address register
// MRD1   | data read, first cycle
// MRD2   | data read, write mdata into Rd
// SGETB  | load Rd (store data) into B
// SPASS  | pass B through ALU into C
// SWR    | data write
// HALT   | stopped until reset
module cpu_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [1:0] sh,
   output logic [2:0] nsel,
   output logic [3:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic [1:0] ALUop,
   output logic [1:0] shift,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       load_addr,
   output logic       addr_sel,
   output logic [1:0] mem_cmd,
   output logic       halted
);
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC, S_CMPX,
      S_WREG, S_ADDR, S_LADDR, S_MRD1, S_MRD2, S_SGETB, S_SPASS, S_SWR, S_HALT
   } state_t;

   state_t state, state_next;

   always_ff @(posedge clk) begin
      if (reset) state <= S_RST;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_RST:  state_next = S_IF1;
         S_IF1:  state_next = S_IF2;
         S_IF2:  state_next = S_UPD;
         S_UPD:  state_next = S_DEC;
         S_DEC: begin
            case (opcode)
               OPC_MOV: begin
                  if (op == 2'b10)      state_next = S_WIMM;
                  else if (op == 2'b00) state_next = S_GETB;
                  else                  state_next = S_IF1;
               end
               // MVN has no Rn operand, so it skips straight to loading B
               OPC_ALU:           state_next = (op == 2'b11) ? S_GETB : S_GETA;
               OPC_LDR, OPC_STR:  state_next = S_GETA;
               OPC_HALT:          state_next = S_HALT;
               default:           state_next = S_IF1;
            endcase
         end
         S_WIMM:  state_next = S_IF1;
         S_GETA:  state_next = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GETB;
         S_GETB:  state_next = (opcode == OPC_ALU && op == 2'b01) ? S_CMPX : S_EXEC;
         S_EXEC:  state_next = S_WREG;
         S_CMPX:  state_next = S_IF1;
         S_WREG:  state_next = S_IF1;
         S_ADDR:  state_next = S_LADDR;
         S_LADDR: state_next = (opcode == OPC_LDR) ? S_MRD1 : S_SGETB;
         S_MRD1:  state_next = S_MRD2;
         S_MRD2:  state_next = S_IF1;
         S_SGETB: state_next = S_SPASS;
         S_SPASS: state_next = S_SWR;
         S_SWR:   state_next = S_IF1;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_RST;
      endcase
   end

   always_comb begin
      nsel      = 3'b000;
      vsel      = 4'b0000;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      ALUop     = 2'b00;
      shift     = 2'b00;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      load_addr = 1'b0;
      addr_sel  = 1'b0;
      mem_cmd   = MEM_NONE;
      halted    = 1'b0;
      case (state)
         S_RST: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
         end
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = MEM_READ;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = MEM_READ;
            load_ir  = 1'b1;
         end
         S_UPD:  load_pc = 1'b1;
         S_WIMM: begin
            nsel  = 3'b001;
            vsel  = 4'b0100;
            write = 1'b1;
         end
         S_GETA: begin
            nsel  = 3'b001;
            loada = 1'b1;
         end
         S_GETB: begin
            nsel  = 3'b100;
            loadb = 1'b1;
         end
         S_EXEC: begin
            shift = sh;
            loadc = 1'b1;
            if (opcode == OPC_MOV) begin
               asel  = 1'b1;
               ALUop = 2'b00;
            end else if (op == 2'b11) begin
               asel  = 1'b1;
               ALUop = 2'b11;
            end else begin
               ALUop = op;
            end
         end
         S_CMPX: begin
            shift = sh;
            ALUop = 2'b01;
            loads = 1'b1;
         end
         S_WREG: begin
            nsel  = 3'b010;
            vsel  = 4'b0001;
            write = 1'b1;
         end
         S_ADDR: begin
            bsel  = 1'b1;
            loadc = 1'b1;
         end
         S_LADDR: load_addr = 1'b1;
         S_MRD1:  mem_cmd = MEM_READ;
         S_MRD2: begin
            mem_cmd = MEM_READ;
            nsel    = 3'b010;
            vsel    = 4'b1000;
            write   = 1'b1;
         end
         S_SGETB: begin
            nsel  = 3'b010;
            loadb = 1'b1;
         end
         S_SPASS: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_SWR:  mem_cmd = MEM_WRITE;
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: each instruction is expanded into its expected
// per-cycle control vector list and compared against the DUT one cycle at a time.
module tb_cpu_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = 3'b000;
   logic [1:0] op = 2'b00;
   logic [1:0] sh = 2'b00;
   logic [2:0] nsel;
   logic [3:0] vsel;
   logic       write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0] ALUop, shift;
   logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
   logic [1:0] mem_cmd;
   logic       halted;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [2:0] nsel;
      logic [3:0] vsel;
      logic       write, loada, loadb, loadc, loads, asel, bsel;
      logic [1:0] alu_op;
      logic [1:0] shift;
      logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
      logic [1:0] mem_cmd;
      logic       halted;
   } ctl_t;

   ctl_t exp_q[$];

   cpu_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .op(op), .sh(sh),
      .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .ALUop(ALUop),
      .shift(shift), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
      .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic ctl_t observed();
      return {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, ALUop, shift,
              load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted};
   endfunction

   function automatic ctl_t rst_vec();
      ctl_t c = '0;
      c.reset_pc = 1'b1;
      c.load_pc  = 1'b1;
      return c;
   endfunction

   // Expected cycle-by-cycle controls for one instruction, starting at the first fetch cycle.
   function automatic void build_expect(input logic [2:0] opc, input logic [1:0] o,
                                        input logic [1:0] s, input int halt_cycles);
      ctl_t c;
      logic mov_imm, mov_reg, alu, mvn, ldr, str_i;
      mov_imm = (opc == 3'b110) && (o == 2'b10);
      mov_reg = (opc == 3'b110) && (o == 2'b00);
      alu     = (opc == 3'b101);
      mvn     = alu && (o == 2'b11);
      ldr     = (opc == 3'b011);
      str_i   = (opc == 3'b100);
      exp_q.delete();
      c = '0; c.addr_sel = 1'b1; c.mem_cmd = 2'b01; exp_q.push_back(c);
      c.load_ir = 1'b1; exp_q.push_back(c);
      c = '0; c.load_pc = 1'b1; exp_q.push_back(c);
      c = '0; exp_q.push_back(c);
      if (opc == 3'b111) begin
         for (int i = 0; i < halt_cycles; i++) begin
            c = '0; c.halted = 1'b1; exp_q.push_back(c);
         end
      end else if (mov_imm) begin
         c = '0; c.nsel = 3'b001; c.vsel = 4'b0100; c.write = 1'b1; exp_q.push_back(c);
      end else if (mov_reg || alu || ldr || str_i) begin
         if (!mov_reg && !mvn) begin
            c = '0; c.nsel = 3'b001; c.loada = 1'b1; exp_q.push_back(c);
         end
         if (ldr || str_i) begin
            c = '0; c.bsel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
            c = '0; c.load_addr = 1'b1; exp_q.push_back(c);
            if (ldr) begin
               c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
               c.nsel = 3'b010; c.vsel = 4'b1000; c.write = 1'b1; exp_q.push_back(c);
            end else begin
               c = '0; c.nsel = 3'b010; c.loadb = 1'b1; exp_q.push_back(c);
               c = '0; c.asel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
               c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
            end
         end else begin
            c = '0; c.nsel = 3'b100; c.loadb = 1'b1; exp_q.push_back(c);
            if (alu && o == 2'b01) begin
               c = '0; c.shift = s; c.alu_op = 2'b01; c.loads = 1'b1; exp_q.push_back(c);
            end else begin
               c = '0; c.shift = s; c.loadc = 1'b1;
               c.asel = mov_reg || mvn;
               c.alu_op = mov_reg ? 2'b00 : o;
               exp_q.push_back(c);
               c = '0; c.nsel = 3'b010; c.vsel = 4'b0001; c.write = 1'b1; exp_q.push_back(c);
            end
         end
      end
   endfunction

   // Called at a falling edge with the DUT in its first fetch cycle; returns in the cycle after
   // the last expected one (next fetch, or still halted).
   task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                            input logic [1:0] s);
      ctl_t act;
      opcode = opc; op = o; sh = s;
      build_expect(opc, o, s, 20);
      for (int i = 0; i < exp_q.size(); i++) begin
         act = observed();
         n_checks++;
         if (act !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s opc=%b op=%b cycle %0d: got %h expected %h",
                     name, opc, o, i + 1, act, exp_q[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic check_rst(input string name);
      n_checks++;
      if (observed() !== rst_vec()) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, observed(), rst_vec());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         check_rst("reset_hold");
      end
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_mov_imm();
      run_instr("mov_imm", 3'b110, 2'b10, 2'b00);
      run_instr("mov_imm_b2b", 3'b110, 2'b10, 2'b11);
   endtask

   task automatic test_add();
      run_instr("add_sh01", 3'b101, 2'b00, 2'b01);
      run_instr("and_sh10", 3'b101, 2'b10, 2'b10);
      run_instr("mvn_sh11", 3'b101, 2'b11, 2'b11);
      run_instr("mov_reg", 3'b110, 2'b00, 2'b01);
   endtask

   task automatic test_cmp();
      run_instr("cmp", 3'b101, 2'b01, 2'b10);
   endtask

   task automatic test_ldr_str();
      run_instr("ldr", 3'b011, 2'b00, 2'b00);
      run_instr("str", 3'b100, 2'b00, 2'b00);
      run_instr("nop_undef", 3'b000, 2'b00, 2'b00);
      run_instr("nop_mov01", 3'b110, 2'b01, 2'b00);
   endtask

   task automatic test_random();
      for (int k = 0; k < 150; k++)
         run_instr("random", 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)));
   endtask

   task automatic test_reset_mid();
      ctl_t act;
      logic write_seen = 1'b0;
      opcode = 3'b101; op = 2'b00; sh = 2'b01;
      build_expect(3'b101, 2'b00, 2'b01, 0);
      for (int i = 0; i < 6; i++) begin
         act = observed();
         write_seen |= write;
         n_checks++;
         if (act !== exp_q[i]) begin
            n_fail++;
            $display("FAIL reset_mid cycle %0d: got %h expected %h", i + 1, act, exp_q[i]);
         end
         if (i < 5) begin
            @(posedge clk); @(negedge clk);
         end
      end
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      write_seen |= write;
      reset = 1'b0;
      check_rst("reset_mid_rst");
      n_checks++;
      if (write_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_no_write: got %b expected 0", write_seen);
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_halt();
      run_instr("halt", 3'b111, 2'b10, 2'b00);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      check_rst("halt_reset");
      @(posedge clk); @(negedge clk);
      run_instr("after_halt", 3'b110, 2'b10, 2'b00);
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_add();
      test_cmp();
      test_ldr_str();
      test_random();
      test_reset_mid();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
